ac97_frame_tx: RTL and testbench
================================

Name: ac97_frame_tx

Overview:
Controller-side AC-link output framer. It serializes one 256-bit AC'97 frame per 256 bit clocks onto SYNC/SDATA_OUT and feeds the codec's serial input (tag, command address/data, PCM left/right).
It runs entirely in the codec bit-clock domain (12.288 MHz). Upstream blocks supply register-write/read commands and stereo PCM samples through valid/ready ports that are sampled once per frame.

Parameters:
SAMPLE_WIDTH, 20, PCM sample width (1..20); left-justified into 20-bit slot, LSBs zero-padded.
WARMUP_FRAMES, 2, frames emitted with tag valid-frame=0 and no handshakes after reset release (1..15).

Ports:
clk  in  1  AC'97 BIT_CLK; all logic on posedge.
rst  in  1  synchronous active-high reset.
cmd_valid  in  1  command pending.
cmd_read  in  1  1=register read request, 0=write.
cmd_addr  in  7  codec register address.
cmd_data  in  16  write data (ignored for reads).
cmd_ready  out  1  command accepted this cycle.
pcm_valid  in  1  sample pair pending.
pcm_left  in  SAMPLE_WIDTH  slot 3 sample.
pcm_right  in  SAMPLE_WIDTH  slot 4 sample.
pcm_ready  out  1  sample pair accepted this cycle.
sync  out  1  AC-link SYNC.
sdata_out  out  1  AC-link SDATA_OUT.
frame_start  out  1  1-cycle pulse, cycle carrying frame bit 0.
underrun  out  1  1-cycle pulse, frame sent without PCM after warmup.

Behaviour:
- Bit position counter pos is 8 bits and wraps 255->0. "Cycle p" = the cycle with pos==p. sdata_out in cycle p carries frame bit p, MSB-first: bits 0-15 = slot0, 16-35 = slot1, 36-55 = slot2, 56-75 = slot3, 76-95 = slot4, 96-255 = 0.
- sync=1 in cycles 255 and 0..14 (16 clocks). Its rise leads slot0 bit15 by one clock, so a codec that registers SYNC starts counting at frame bit 0.
- sync, sdata_out and frame_start are registered outputs (no combinational path from inputs). frame_start=1 in cycle 0.
- Reset: pos<=254, sync=0, sdata_out=0, frame_start=0, underrun=0, warmup counter=0, latched slots cleared. Reset mid-frame abandons the frame immediately. The first sync rise is in the 2nd cycle after rst falls.
- Warmup: the counter increments in cycle 255 and saturates at WARMUP_FRAMES. While the counter is below WARMUP_FRAMES: cmd_ready=pcm_ready=0, the tag is all-zero, and sdata_out=0 for the whole frame.
- Capture: in cycle 254 only, with warmup done and not in reset, cmd_ready=cmd_valid and pcm_ready=pcm_valid (combinational). Accepted fields are latched at that clock edge and used for the frame whose bit 0 follows 2 cycles later. No acceptance in any other cycle. At most one command and one sample pair per frame.
- Tag (slot0[15:0]):
  - bit15 valid frame = 1 after warmup.
  - bit14 = command taken.
  - bit13 = command taken and write.
  - bit12 = bit11 = PCM taken.
  - bits 10:0 = 0.
- Slot1: {cmd_read, cmd_addr, 12'h000} if command taken, else 0.
- Slot2: {cmd_data, 4'h0} if command taken and write, else 0.
- Slot3/Slot4: {sample, (20-SAMPLE_WIDTH) zeros} if PCM taken, else 0.
- Underrun: after warmup, pcm_valid=0 in cycle 254 -> underrun=1 in cycle 255 and slots 3/4 are tagged invalid. A missing command is normal and not flagged.
- Simultaneous command and PCM in the same frame: both taken, no priority needed.
- Inputs may change at any time. Only cycle-254 values matter.

Decomposition:
- Shared package ac97_pkg:
  - frame length 256, slot widths 16/20, slot start bits 0/16/36/56/76.
  - tag bit indices (VALID=15, SLOT1=14, SLOT2=13, SLOT3=12, SLOT4=11).
  - SYNC length 16, capture position 254.
  - register address constants for master volume 0x02 and PCM out volume 0x18.
- One sub-module, ac97_slot_builder: combinational assembly of the 96-bit payload (slots 0-4) from the latched fields. The top holds the counter, warmup, handshake and shift/output registers.

Test Plan:
- Reset then idle, WARMUP_FRAMES=2: sync low 1 cycle after release, then high exactly 16 cycles every 256. sdata_out all 0 for 2 frames. cmd_ready/pcm_ready never high during warmup.
- Write addr 0x02 data 0x8000 held valid after warmup: cmd_ready high exactly once (cycle 254). Next frame serializes tag 0xE000, slot1 0x02000, slot2 0x80000. Codec model ControlRegs[2]==0x8000.
- PCM L=0x12345, R=0xABCDE, SAMPLE_WIDTH=20: tag 0x9800, slot3 bits 56-75 = 0x12345, slot4 bits 76-95 = 0xABCDE. With SAMPLE_WIDTH=16, L=0x1234 gives slot3 0x12340.
- pcm_valid low in cycle 254 after warmup: underrun=1 in cycle 255. Tag bits 12/11=0, slots 3/4 zero, tag 0x8000.
- Read addr 0x7C plus PCM in the same frame: both readies high in cycle 254. Tag 0xD800, slot1 0xFC000, slot2 0.
- rst asserted at pos 100 mid-frame: next cycle sync=0, sdata_out=0. Warmup restarts: no handshakes for 2 frames after release.

Source files
------------

// File: rtl/ac97_pkg.sv
// Shared AC-link frame geometry, tag layout and codec register addresses.
package ac97_pkg;

   localparam int unsigned FRAME_LEN   = 256;
   localparam int unsigned SLOT0_W     = 16;
   localparam int unsigned SLOT_W      = 20;
   localparam int unsigned SLOT0_START = 0;
   localparam int unsigned SLOT1_START = 16;
   localparam int unsigned SLOT2_START = 36;
   localparam int unsigned SLOT3_START = 56;
   localparam int unsigned SLOT4_START = 76;
   localparam int unsigned PAYLOAD_W   = 96;

   localparam int unsigned TAG_VALID = 15;
   localparam int unsigned TAG_SLOT1 = 14;
   localparam int unsigned TAG_SLOT2 = 13;
   localparam int unsigned TAG_SLOT3 = 12;
   localparam int unsigned TAG_SLOT4 = 11;

   localparam int unsigned SYNC_LEN    = 16;
   localparam logic [7:0]  CAPTURE_POS = 8'd254;
   localparam logic [7:0]  LAST_POS    = 8'd255;

   localparam logic [6:0] REG_MASTER_VOL  = 7'h02;
   localparam logic [6:0] REG_PCM_OUT_VOL = 7'h18;

   typedef struct packed {
      logic        frame_valid;
      logic        cmd_taken;
      logic        cmd_read;
      logic [6:0]  cmd_addr;
      logic [15:0] cmd_data;
      logic        pcm_taken;
   } frame_ctrl_t;

   // SYNC covers the last bit of the previous frame plus the first 15 tag bits.
   function automatic logic in_sync(input logic [7:0] pos);
      return (pos == LAST_POS) || (pos < 8'(SYNC_LEN - 1));
   endfunction

endpackage

// File: rtl/ac97_slot_builder.sv
// Combinational assembly of the 96-bit slot 0-4 payload, MSB is frame bit 0.
module ac97_slot_builder
   import ac97_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = 20
) (
   input  frame_ctrl_t                 ctrl,
   input  logic [SAMPLE_WIDTH-1:0]     pcm_left,
   input  logic [SAMPLE_WIDTH-1:0]     pcm_right,
   output logic [PAYLOAD_W-1:0]        payload
);

   logic [SLOT0_W-1:0] tag;
   logic [SLOT_W-1:0]  slot1, slot2, slot3, slot4;

   always_comb begin
      tag   = '0;
      slot1 = '0;
      slot2 = '0;
      slot3 = '0;
      slot4 = '0;
      if (ctrl.frame_valid) begin
         tag[TAG_VALID] = 1'b1;
         tag[TAG_SLOT1] = ctrl.cmd_taken;
         tag[TAG_SLOT2] = ctrl.cmd_taken & ~ctrl.cmd_read;
         tag[TAG_SLOT3] = ctrl.pcm_taken;
         tag[TAG_SLOT4] = ctrl.pcm_taken;
      end
      if (ctrl.cmd_taken) begin
         slot1 = {ctrl.cmd_read, ctrl.cmd_addr, 12'h000};
      end
      if (ctrl.cmd_taken && !ctrl.cmd_read) begin
         slot2 = {ctrl.cmd_data, 4'h0};
      end
      // Narrow samples are left-justified; the shift zero-pads the LSBs.
      if (ctrl.pcm_taken) begin
         slot3 = SLOT_W'(pcm_left) << (SLOT_W - SAMPLE_WIDTH);
         slot4 = SLOT_W'(pcm_right) << (SLOT_W - SAMPLE_WIDTH);
      end
   end

   always_comb begin
      payload = '0;
      payload[PAYLOAD_W-1-SLOT0_START -: SLOT0_W] = tag;
      payload[PAYLOAD_W-1-SLOT1_START -: SLOT_W]  = slot1;
      payload[PAYLOAD_W-1-SLOT2_START -: SLOT_W]  = slot2;
      payload[PAYLOAD_W-1-SLOT3_START -: SLOT_W]  = slot3;
      payload[PAYLOAD_W-1-SLOT4_START -: SLOT_W]  = slot4;
   end

endmodule

// File: rtl/ac97_frame_tx.sv
// AC-link output framer: bit counter, warmup, once-per-frame handshakes and
// the registered SYNC/SDATA_OUT serializer.
module ac97_frame_tx
   import ac97_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH  = 20,
   parameter int unsigned WARMUP_FRAMES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   input  logic                    cmd_read,
   input  logic [6:0]              cmd_addr,
   input  logic [15:0]             cmd_data,
   output logic                    cmd_ready,
   input  logic                    pcm_valid,
   input  logic [SAMPLE_WIDTH-1:0] pcm_left,
   input  logic [SAMPLE_WIDTH-1:0] pcm_right,
   output logic                    pcm_ready,
   output logic                    sync,
   output logic                    sdata_out,
   output logic                    frame_start,
   output logic                    underrun
);

   logic [7:0]              pos_q, pos_next;
   logic [3:0]              warm_cnt_q;
   logic                    warm_done;
   logic                    capture;
   frame_ctrl_t             ctrl_q, ctrl_d;
   logic [SAMPLE_WIDTH-1:0] left_q, right_q;
   logic [PAYLOAD_W-1:0]    payload;
   logic [PAYLOAD_W-1:0]    shift_q;

   assign pos_next  = pos_q + 8'd1;
   assign warm_done = (warm_cnt_q == 4'(WARMUP_FRAMES));
   assign capture   = (pos_q == CAPTURE_POS) && warm_done && !rst;
   assign cmd_ready = capture && cmd_valid;
   assign pcm_ready = capture && pcm_valid;

   always_comb begin
      ctrl_d = ctrl_q;
      if (pos_q == CAPTURE_POS) begin
         ctrl_d.frame_valid = warm_done;
         ctrl_d.cmd_taken   = cmd_ready;
         ctrl_d.cmd_read    = cmd_read;
         ctrl_d.cmd_addr    = cmd_addr;
         ctrl_d.cmd_data    = cmd_data;
         ctrl_d.pcm_taken   = pcm_ready;
      end
   end

   ac97_slot_builder #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH)
   ) u_slot_builder (
      .ctrl      (ctrl_q),
      .pcm_left  (left_q),
      .pcm_right (right_q),
      .payload   (payload)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q       <= CAPTURE_POS;
         warm_cnt_q  <= '0;
         ctrl_q      <= '0;
         left_q      <= '0;
         right_q     <= '0;
         shift_q     <= '0;
         sync        <= 1'b0;
         sdata_out   <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         pos_q  <= pos_next;
         ctrl_q <= ctrl_d;
         if (pos_q == LAST_POS && !warm_done) begin
            warm_cnt_q <= warm_cnt_q + 4'd1;
         end
         if (pcm_ready) begin
            left_q  <= pcm_left;
            right_q <= pcm_right;
         end
         // Outputs are loaded one clock early so they line up with pos.
         sync        <= in_sync(pos_next);
         frame_start <= (pos_next == 8'd0);
         underrun    <= (pos_q == CAPTURE_POS) && warm_done && !pcm_valid;
         if (pos_q == LAST_POS) begin
            sdata_out <= payload[PAYLOAD_W-1];
            shift_q   <= {payload[PAYLOAD_W-2:0], 1'b0};
         end else begin
            sdata_out <= shift_q[PAYLOAD_W-1];
            shift_q   <= {shift_q[PAYLOAD_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Bench for ac97_frame_tx: whole-frame captures compared against a slot-level
// frame model, with a 20-bit and a 16-bit sample instance side by side.
module tb_ac97_frame_tx;
   import ac97_pkg::*;

   localparam int unsigned WARM = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_read;
   logic [6:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        pcm_valid;
   logic [19:0] pcm_left, pcm_right;
   logic        cmd_ready, pcm_ready, sync, sdata_out, frame_start, underrun;
   logic        cmd_ready16, pcm_ready16, sync16, sdata16, frame_start16, underrun16;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          n_cap  = 0;
   logic [15:0] regs [128];
   logic [15:0] tag;
   logic [15:0] rdata;

   always #5 clk = ~clk;

   ac97_frame_tx #(.SAMPLE_WIDTH(20), .WARMUP_FRAMES(WARM)) u20 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_read(cmd_read),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .pcm_valid(pcm_valid), .pcm_left(pcm_left), .pcm_right(pcm_right),
      .pcm_ready(pcm_ready), .sync(sync), .sdata_out(sdata_out),
      .frame_start(frame_start), .underrun(underrun)
   );

   ac97_frame_tx #(.SAMPLE_WIDTH(16), .WARMUP_FRAMES(WARM)) u16 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_read(cmd_read),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready16),
      .pcm_valid(pcm_valid), .pcm_left(pcm_left[19:4]), .pcm_right(pcm_right[19:4]),
      .pcm_ready(pcm_ready16), .sync(sync16), .sdata_out(sdata16),
      .frame_start(frame_start16), .underrun(underrun16)
   );

   task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // Frame bit p of the model is what the codec should see in cycle p.
   function automatic logic [255:0] model_frame(input bit warm, input bit ct, input bit rd,
                                                input logic [6:0] addr, input logic [15:0] data,
                                                input bit pt, input logic [19:0] l,
                                                input logic [19:0] r, input int sw);
      logic [255:0] f;
      logic [15:0]  t;
      logic [19:0]  s1, s2, s3, s4;
      int           acc;
      f = '0;
      if (!warm) return f;
      acc = 'h8000;
      if (ct) acc += 'h4000;
      if (ct && !rd) acc += 'h2000;
      if (pt) acc += 'h1800;
      t  = 16'(acc);
      s1 = ct ? 20'(int'(rd) * 'h80000 + int'(addr) * 'h1000) : '0;
      s2 = (ct && !rd) ? 20'(int'(data) * 16) : '0;
      s3 = pt ? 20'((int'(l) % (1 << sw)) * (1 << (20 - sw))) : '0;
      s4 = pt ? 20'((int'(r) % (1 << sw)) * (1 << (20 - sw))) : '0;
      for (int i = 0; i < 16; i++) f[i] = t[15-i];
      for (int i = 0; i < 20; i++) begin
         f[16+i] = s1[19-i];
         f[36+i] = s2[19-i];
         f[56+i] = s3[19-i];
         f[76+i] = s4[19-i];
      end
      return f;
   endfunction

   task automatic randomize_inputs();
      cmd_valid = 1'($urandom);
      cmd_read  = 1'($urandom);
      cmd_addr  = 7'($urandom);
      cmd_data  = 16'($urandom);
      pcm_valid = 1'($urandom);
      pcm_left  = 20'($urandom);
      pcm_right = 20'($urandom);
   endtask

   // Entered at the negedge of cycle 254; returns at the next cycle 254.
   task automatic do_frame(input bit cv, input bit rd, input logic [6:0] addr,
                           input logic [15:0] data, input bit pv, input logic [19:0] l,
                           input logic [19:0] r, output logic [15:0] obs_tag);
      logic [255:0] o_sync, o_sd, o_sd16, o_fs, o_ur, e_sync, e_fs, e_ur;
      int           cr_cnt, pr_cnt, p;
      bit           warm;
      logic [6:0]   a;
      logic [15:0]  d;
      warm   = (n_cap >= int'(WARM));
      n_cap++;
      cr_cnt = 0;
      pr_cnt = 0;
      e_sync = '0;
      e_fs   = '0;
      e_ur   = '0;
      for (int c = 0; c < 256; c++) begin
         p = (254 + c) % 256;
         if (c == 0) begin
            cmd_valid = cv; cmd_read = rd; cmd_addr = addr; cmd_data = data;
            pcm_valid = pv; pcm_left = l;  pcm_right = r;
         end else begin
            randomize_inputs();
         end
         #1;
         cr_cnt += int'(cmd_ready) + int'(cmd_ready16);
         pr_cnt += int'(pcm_ready) + int'(pcm_ready16);
         o_sync[p] = sync;
         o_sd[p]   = sdata_out;
         o_sd16[p] = sdata16;
         o_fs[p]   = frame_start;
         o_ur[p]   = underrun;
         e_sync[p] = (p == 255) || (p < 15);
         @(negedge clk);
      end
      e_fs[0]   = 1'b1;
      e_ur[255] = warm && !pv;
      check("cmd_ready_count", 256'(cr_cnt), (warm && cv) ? 256'd2 : 256'd0);
      check("pcm_ready_count", 256'(pr_cnt), (warm && pv) ? 256'd2 : 256'd0);
      check("sync_pattern", o_sync, e_sync);
      check("frame_start", o_fs, e_fs);
      check("underrun", o_ur, e_ur);
      check("sdata_w20", o_sd, model_frame(warm, warm && cv, rd, addr, data, warm && pv,
                                           l, r, 20));
      check("sdata_w16", o_sd16, model_frame(warm, warm && cv, rd, addr, data, warm && pv,
                                             l >> 4, r >> 4, 16));
      for (int i = 0; i < 16; i++) obs_tag[15-i] = o_sd[i];
      // Codec side: apply register writes decoded from the serial stream.
      if (obs_tag[15] && obs_tag[14] && obs_tag[13]) begin
         for (int i = 0; i < 7; i++) a[6-i] = o_sd[17+i];
         for (int i = 0; i < 16; i++) d[15-i] = o_sd[36+i];
         regs[a] = d;
      end
   endtask

   task automatic reset_release();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", 256'({sync, sdata_out, frame_start, underrun, cmd_ready, pcm_ready,
                                  sync16, sdata16, frame_start16, underrun16}), 256'd0);
      rst   = 1'b0;
      n_cap = 0;
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_data = '0;
      pcm_valid = 1'b0; pcm_left = '0; pcm_right = '0;
      @(negedge clk);
      reset_release();

      // Warmup: requests held valid must not be accepted.
      do_frame(1'b1, 1'b0, 7'h11, 16'h1111, 1'b1, 20'h11111, 20'h22222, tag);
      check("warmup_tag0", 256'(tag), 256'h0);
      do_frame(1'b1, 1'b0, 7'h22, 16'h2222, 1'b1, 20'h33333, 20'h44444, tag);
      check("warmup_tag1", 256'(tag), 256'h0);

      do_frame(1'b1, 1'b0, REG_MASTER_VOL, 16'h8000, 1'b0, 20'h0, 20'h0, tag);
      check("write_tag", 256'(tag), 256'hE000);
      check("codec_master_vol", 256'(regs[REG_MASTER_VOL]), 256'h8000);

      do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 20'h12345, 20'hABCDE, tag);
      check("pcm_tag", 256'(tag), 256'h9800);

      do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 20'h54321, 20'h0FEDC, tag);
      check("underrun_tag", 256'(tag), 256'h8000);

      do_frame(1'b1, 1'b1, 7'h7C, 16'hDEAD, 1'b1, 20'h01234, 20'hF0F0F, tag);
      check("read_pcm_tag", 256'(tag), 256'hD800);

      rdata = 16'($urandom);
      do_frame(1'b1, 1'b0, REG_PCM_OUT_VOL, rdata, 1'b1, 20'($urandom), 20'($urandom), tag);
      check("codec_pcm_out_vol", 256'(regs[REG_PCM_OUT_VOL]), 256'(rdata));

      for (int k = 0; k < 6; k++) begin
         do_frame(1'($urandom), 1'($urandom), 7'($urandom), 16'($urandom), 1'($urandom),
                  20'($urandom), 20'($urandom), tag);
      end

      // Mid-frame reset at pos 100, then warmup must restart.
      for (int c = 0; c < 102; c++) begin
         randomize_inputs();
         @(negedge clk);
      end
      cmd_valid = 1'b1;
      pcm_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("midframe_reset", 256'({sync, sdata_out, frame_start, underrun, sync16, sdata16}),
            256'd0);
      reset_release();
      do_frame(1'b1, 1'b0, 7'h05, 16'h5555, 1'b1, 20'h55555, 20'h66666, tag);
      do_frame(1'b1, 1'b1, 7'h06, 16'h6666, 1'b1, 20'h77777, 20'h88888, tag);
      do_frame(1'b1, 1'b1, 7'h26, 16'h0000, 1'b1, 20'h9ABCD, 20'h13579, tag);
      check("post_reset_tag", 256'(tag), 256'hD800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
